// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel registered mux.
// Holds mode encodings, default sizes and a modulo-N pointer increment.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int NUM_CH_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // Next channel index after p, wrapping to 0 past n-1.
    function automatic int unsigned ptr_inc(
        input int unsigned p,
        input int unsigned n
    );
        return (p + 32'd1 >= n) ? 32'd0 : p + 32'd1;
    endfunction

endpackage

// File: rtl/mux_nch_rr_if.sv
// Handshake bundle of mux_nch_rr: channel inputs, select and output stage.
// slave = mux side, master = driving side; sel_err only with MUX_SEL_ERR_EN.
interface mux_nch_rr_if
    import mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic                       mode;
    logic [SEL_W-1:0]           sel;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH-1:0]          in_ready;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [SEL_W-1:0]           out_ch;
`ifdef MUX_SEL_ERR_EN
    logic                       sel_err;
`endif

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
`ifdef MUX_SEL_ERR_EN
        , output sel_err
`endif
    );

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
`ifdef MUX_SEL_ERR_EN
        , input sel_err
`endif
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search starting just after ptr.
// in: req, ptr, enable; out: grant index, grant_vld.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              enable,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_vld
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = SEL_W'(ptr_inc(32'(idx), NUM_CH));
            if (enable && !grant_vld && req[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nch_rr.sv
// Registered N-channel mux, manual select or round-robin, valid/ready output.
// Ports: clk, rst_n, bus (mux_nch_rr_if.slave). Option: MUX_SEL_ERR_EN.
module mux_nch_rr
    import mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_nch_rr_if.slave   bus
);

    localparam int SEL_W = $clog2(NUM_CH);

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  arb_grant;
    logic              arb_vld;
    logic              sel_ok;
    logic              man_vld;
    logic [SEL_W-1:0]  grant;
    logic              grant_vld;
    logic              accept;
    logic              xfer;
    logic [NUM_CH-1:0] rdy;

    logic [DATA_W-1:0] data_q;
    logic [SEL_W-1:0]  ch_q;
    logic              vld_q;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr),
        .enable    (bus.mode == MODE_RR),
        .grant     (arb_grant),
        .grant_vld (arb_vld)
    );

    // Out-of-range sel is masked before indexing in_valid.
    assign sel_ok  = 32'(bus.sel) < NUM_CH;
    assign man_vld = sel_ok && bus.in_valid[bus.sel];

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        unique case (1'b1)
            (bus.mode == MODE_RR): begin
                grant     = arb_grant;
                grant_vld = arb_vld;
            end
            default: begin
                grant     = bus.sel;
                grant_vld = man_vld;
            end
        endcase
    end

    assign accept = !vld_q || bus.out_ready;
    assign xfer   = accept && grant_vld;

    always_comb begin
        rdy = '0;
        if (xfer)
            rdy[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            ch_q   <= '0;
            rr_ptr <= SEL_W'(NUM_CH - 1);
        end else if (xfer) begin
            vld_q  <= 1'b1;
            data_q <= bus.in_data[32'(grant)*DATA_W +: DATA_W];
            ch_q   <= grant;
            if (bus.mode == MODE_RR)
                rr_ptr <= grant;
        end else if (bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

`ifdef MUX_SEL_ERR_EN
    logic err_q;
    logic err_now;

    // Bad select, or selected channel idle while others wait.
    assign err_now = (bus.mode == MODE_MANUAL) &&
                     (!sel_ok || (!man_vld && |bus.in_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (err_now)
            err_q <= 1'b1;
    end

    assign bus.sel_err = err_q;
`endif

    assign bus.in_ready  = rdy;
    assign bus.out_data  = data_q;
    assign bus.out_valid = vld_q;
    assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_mux_nch_rr.sv
// Randomised and directed bench for mux_nch_rr against a queue-free model.
// Uses a 4-channel instance plus a 3-channel one for out-of-range select.
module tb_mux_nch_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mux_nch_rr_if #(.NUM_CH(4), .DATA_W(8)) b  ();
    mux_nch_rr_if #(.NUM_CH(3), .DATA_W(8)) b3 ();

    mux_nch_rr #(.NUM_CH(4), .DATA_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    mux_nch_rr #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    // Reference state: last round-robin winner and the output word.
    int         m_last;
    bit         m_vld;
    logic [7:0] m_data;
    int         m_ch;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mgrant();
        if (b.mode == 1'b0)
            return b.in_valid[b.sel] ? int'(b.sel) : -1;
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (m_last + k) % 4;
            if (b.in_valid[j])
                return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 3;
        m_vld  = 1'b0;
        m_data = 8'h00;
        m_ch   = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One cycle: check ready before the edge, output after it.
    task automatic tick(input string tag);
        int         g;
        bit         acc;
        logic [3:0] exp_rdy;
        #1;
        acc = !m_vld || b.out_ready;
        g   = mgrant();
        exp_rdy = (acc && g >= 0) ? 4'(1 << g) : 4'b0000;
        chk({tag, "_rdy"}, 64'(b.in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (acc && g >= 0) begin
            m_vld  = 1'b1;
            m_data = b.in_data[g*8 +: 8];
            m_ch   = g;
            if (b.mode)
                m_last = g;
        end else if (b.out_ready) begin
            m_vld = 1'b0;
        end
        #1;
        chk({tag, "_vld"}, 64'(b.out_valid), 64'(m_vld));
        chk({tag, "_data"}, 64'(b.out_data), 64'(m_data));
        chk({tag, "_ch"}, 64'(b.out_ch), 64'(m_ch));
    endtask

    initial begin
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};

        b.mode = 0; b.sel = 0; b.in_data = 0;
        b.in_valid = 0; b.out_ready = 0;
        b3.mode = 0; b3.sel = 0; b3.in_data = 0;
        b3.in_valid = 0; b3.out_ready = 0;
        model_reset();

        #1;
        chk("rst_vld", 64'(b.out_valid), 64'd0);
        chk("rst_data", 64'(b.out_data), 64'd0);
        chk("rst_ch", 64'(b.out_ch), 64'd0);
        do_reset();

        // Manual select of channel 2
        b.mode = 0; b.sel = 2; b.in_valid = 4'b0100;
        b.in_data = 32'h00A5_0000; b.out_ready = 1;
        #1;
        chk("man_rdy_k", 64'(b.in_ready), 64'h4);
        tick("man");
        chk("man_data_k", 64'(b.out_data), 64'hA5);
        chk("man_ch_k", 64'(b.out_ch), 64'd2);

        // Round-robin fairness, all channels busy
        b.mode = 1; b.in_valid = 4'b1111; b.out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            b.in_data = $urandom;
            tick("rr");
            chk("rr_seq", 64'(b.out_ch), 64'(exp_seq[i]));
        end

        // Backpressure
        do_reset();
        b.mode = 1; b.in_valid = 4'b1111; b.out_ready = 1;
        b.in_data = $urandom;
        tick("bp0");
        b.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            b.in_data = $urandom;
            tick("bp_hold");
            chk("bp_ch_k", 64'(b.out_ch), 64'd0);
        end
        b.out_ready = 1;
        tick("bp_rel");
        chk("bp_rel_k", 64'(b.out_ch), 64'd1);

        // Sparse requests with wrap
        do_reset();
        b.mode = 1; b.out_ready = 1; b.in_data = $urandom;
        b.in_valid = 4'b0010;
        tick("sp1");
        chk("sp1_k", 64'(b.out_ch), 64'd1);
        b.in_valid = 4'b1001;
        tick("sp3");
        chk("sp3_k", 64'(b.out_ch), 64'd3);
        tick("sp0");
        chk("sp0_k", 64'(b.out_ch), 64'd0);

        // Reset mid-stream
        b.in_valid = 4'b1111; b.in_data = 32'hFFFF_FFFF;
        tick("pre_rst");
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(b.out_valid), 64'd0);
        chk("mid_rst_data", 64'(b.out_data), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        tick("post_rst");
        chk("post_rst_k", 64'(b.out_ch), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            b.mode      = 1'($urandom_range(0, 1));
            b.sel       = 2'($urandom_range(0, 3));
            b.in_valid  = 4'($urandom);
            b.in_data   = $urandom;
            b.out_ready = ($urandom_range(0, 3) != 0);
            tick("rnd");
        end

        // Out-of-range select on a 3-channel mux
        do_reset();
`ifdef MUX_SEL_ERR_EN
        chk("err_rst", 64'(b3.sel_err), 64'd0);
`endif
        b3.mode = 1; b3.in_valid = 3'b111;
        b3.in_data = 24'h33_22_11; b3.out_ready = 0;
        @(posedge clk);
        #1;
        chk("oor_fill", 64'(b3.out_valid), 64'd1);
        b3.mode = 0; b3.sel = 2'd3; b3.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("oor_rdy", 64'(b3.in_ready), 64'd0);
            @(posedge clk);
            #1;
            chk("oor_vld", 64'(b3.out_valid), 64'd0);
`ifdef MUX_SEL_ERR_EN
            chk("oor_err", 64'(b3.sel_err), 64'd1);
`endif
        end
`ifdef MUX_SEL_ERR_EN
        b3.sel = 2'd0;
        @(posedge clk);
        #1;
        chk("err_sticky", 64'(b3.sel_err), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mux_nch_rr.md
Name: mux_nch_rr

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. Successor to the combinational 4:1 select mux.
- Each input channel has a valid/ready handshake. One channel is chosen per transfer, either by an explicit select or by fair round-robin.
- The chosen word is registered into a single output stage, also with valid/ready, that feeds downstream datapath blocks.

Parameters:
- NUM_CH, 4, number of input channels, 2..16.
- DATA_W, 8, data width per channel, 1..64.
- SEL_W, $clog2(NUM_CH), width of the select and channel-ID fields. Derived; do not override.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = manual select, 1 = round-robin.
- sel  in  SEL_W  manual channel select; ignored when mode=1.
- in_data  in  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- in_valid  in  NUM_CH  per-channel valid.
- in_ready  out  NUM_CH  per-channel ready.
- out_data  out  DATA_W  registered selected word.
- out_valid  out  1  output holds an untaken word.
- out_ready  in  1  downstream accepts.
- out_ch  out  SEL_W  source channel of out_data.
- sel_err  out  1  sticky error flag; present only with MUX_SEL_ERR_EN.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1 (channel 0 has first priority), sel_err=0.
- accept = !out_valid || out_ready. This allows one transfer per cycle, back-to-back, without bubbles.
- Grant in manual mode (mode=0):
  - grant = sel, if sel < NUM_CH and in_valid[sel] is high.
  - Otherwise no grant.
- Grant in round-robin mode (mode=1):
  - grant = the first k with in_valid[k] high, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - No grant if no input is valid.
- in_ready[k] = accept && grant valid && grant==k. This is combinational, at most one bit high, and does not depend on in_valid of other channels beyond the arbitration.
- Transfer occurs when in_valid[k] && in_ready[k]. On the next edge:
  - out_data <= channel k data, out_ch <= k, out_valid <= 1.
  - In round-robin mode, rr_ptr <= k.
- Latency: 1 cycle from input transfer to out_valid.
- Output drained with no new transfer: out_valid <= 0 when out_ready && !grant. out_data and out_ch hold their last values.
- Stall (out_valid && !out_ready): all in_ready are low, and out_data/out_ch are held stable.
- rr_ptr changes only on a round-robin transfer. A manual transfer does not move it.
- Wrap-around: rr_ptr=NUM_CH-1 searches from channel 0.
- Mode or sel changes:
  - Take effect at the same-cycle arbitration.
  - Never disturb a word already held in the output register.
- Out-of-range sel is only possible when NUM_CH is not a power of 2. The channel is never granted, so the block does not stall on it; the output simply drains.
- Reset mid-transfer: the held word is dropped, and the output is invalid on the first cycle after release.
- No X propagation: out_data never samples an ungranted channel.

Optional Feature:
- Macro: MUX_SEL_ERR_EN.
- Defined:
  - sel_err port exists.
  - Sets on any cycle with mode=0 and sel >= NUM_CH, or with mode=0 and in_valid[sel]=0 while another in_valid is high (starvation hint).
  - Sticky until reset.
- Undefined:
  - Port is absent, with no logic.
  - Behaviour is otherwise identical.

Decomposition:
- Package mux_pkg:
  - MODE_MANUAL=1'b0, MODE_RR=1'b1.
  - Defaults NUM_CH_DEF=4, DATA_W_DEF=8.
  - Function for modulo-N pointer increment.
- Sub-module rr_arbiter:
  - Parameter NUM_CH.
  - Inputs: req, ptr, enable. Outputs: grant index, grant_vld.
  - Purely combinational; rr_ptr itself stays in the top level.
- The top level holds the output register, handshake logic, manual-select path and the optional error logic.

Test Plan:
- Manual path: mode=0, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1 with one word per cycle and no bubbles.
- Backpressure: round-robin, all valid, out_ready=0 for 3 cycles after the first word → out_data/out_ch held, in_ready=0; after release, the next grant is ch1.
- Sparse requests with wrap: rr_ptr=3, in_valid=4'b0010 → grant ch1; then in_valid=4'b1001 → grant ch3, then ch0.
- Out-of-range select: NUM_CH=3, mode=0, sel=3, all valid → no in_ready ever; out_valid drains to 0; with MUX_SEL_ERR_EN, sel_err=1 and it stays set.
- Reset mid-stream: assert rst_n=0 while out_valid=1 → out_valid=0 and out_data=0 immediately; after release, ch0 is granted first in round-robin mode.
